mac_cfg_loader: RTL
===================

MAC_CFG_LOADER -- requirements
Module: mac_cfg_loader

Interface
REQ-001: Parameter MAC_CONF_WIDTH, default 4, SHALL set the config-field width: signed, mac/mul, 2-bit mode.
REQ-002: Parameter MAC_MIN_WIDTH, default 8, SHALL set the minimum operand width.
REQ-003: Parameter MAC_MULT_WIDTH, default 2*MAC_MIN_WIDTH, SHALL set the product width.
REQ-004: Parameter MAC_ACC_WIDTH, default 2*MAC_MULT_WIDTH, SHALL set the accumulator width.
REQ-005: Parameter CHUNK_WIDTH, default 8, SHALL set the input beat width.
REQ-006: Derived CFG_WIDTH = 4*MAC_ACC_WIDTH+MAC_CONF_WIDTH (132) and NUM_BEATS = ceil(CFG_WIDTH/CHUNK_WIDTH) (17) SHALL be localparams.
REQ-007: clk  input  1  sole clock; all state changes on its rising edge.
REQ-008: rst  input  1  synchronous, active-high reset.
REQ-009: en  input  1  beat-acceptance enable.
REQ-010: in_data  input  CHUNK_WIDTH  config beat payload.
REQ-011: in_valid  input  1  in_data/in_last valid.
REQ-012: in_last  input  1  marks final beat of a frame.
REQ-013: in_ready  output  1  loader accepts a beat this cycle.
REQ-014: cfg  output  CFG_WIDTH  committed config word for the MAC cluster cfg bus.
REQ-015: cset  output  1  one-cycle strobe; cluster registers cfg when high.
REQ-016: busy  output  1  frame partially received (state LOAD).
REQ-017: err  output  1  sticky framing-error flag.

Function
REQ-018: Beat accept SHALL occur when in_valid && in_ready; in_ready SHALL equal en && !rst && state != COMMIT, combinational from registered state.
REQ-019: States SHALL be IDLE, LOAD, COMMIT; beat counter SHALL count accepted beats 0..NUM_BEATS-1.
REQ-020: Beat k SHALL be written to shadow bits [k*CHUNK_WIDTH +: CHUNK_WIDTH], so beat 0 carries cfg[MAC_CONF_WIDTH-1:0]; bits at or above CFG_WIDTH in the final beat (top 4 bits at default) SHALL be discarded.
REQ-021: IDLE: an accept SHALL clear err, store beat 0, and go to LOAD, or go to IDLE with err=1 if in_last=1 (NUM_BEATS>1).
REQ-022: LOAD, accept with counter < NUM_BEATS-1 and in_last=0: store the beat, increment the counter, stay in LOAD.
REQ-023: LOAD, accept with counter < NUM_BEATS-1 and in_last=1: discard the frame, set err=1, clear the counter, go to IDLE; cfg unchanged; no cset.
REQ-024: LOAD, accept with counter == NUM_BEATS-1 and in_last=1: load cfg from shadow plus this beat on that edge, go to COMMIT.
REQ-025: LOAD, accept with counter == NUM_BEATS-1 and in_last=0: discard the frame, set err=1, go to IDLE.
REQ-026: COMMIT SHALL assert cset for exactly one cycle, independent of en, then go to IDLE with the counter cleared.
REQ-027: Latency: final beat accepted on edge N makes cfg new and cset=1 during cycle N+1; in_ready may be 1 again in cycle N+2.
REQ-028: cfg SHALL change only on a successful commit and SHALL hold stable while cset=1 and until the next commit.
REQ-029: en=0 SHALL block accepts and freeze the counter and shadow; partial frames survive en gaps.
REQ-030: in_data/in_last SHALL be ignored when no accept occurs.
REQ-031: busy SHALL be 1 exactly when state == LOAD.

Reset
REQ-032: rst=1 SHALL force state IDLE, counter 0, shadow 0, cfg 0, cset 0, err 0, busy 0, in_ready 0.
REQ-033: rst mid-frame or during COMMIT SHALL abort with no cset pulse; the next accepted beat is beat 0.

Verification
REQ-034: Full frame: 17 beats 0x01..0x11, in_last on beat 17, en=1 -> one cset pulse the cycle after beat 17, cfg[7:0]=0x01, cfg[131:128]=0x1 (upper nibble of 0x11 dropped), err=0.
REQ-035: Early last: in_last on beat 5 -> err=1, no cset, cfg unchanged; next good frame -> err cleared on its first beat, cset once.
REQ-036: Missing last: 17 beats with in_last=0 -> err=1, no cset, IDLE; beat 18 treated as beat 0.
REQ-037: Backpressure: in_valid held 1 over commit -> in_ready=0 in the cset cycle, beat accepted next cycle as new beat 0; en toggled 0 for 3 cycles mid-frame -> no accepts, frame completes normally.
REQ-038: rst asserted after beat 9 -> all outputs 0 next cycle; following full frame of 0xFF beats -> cfg = all ones (132 bits), single cset.

Source files
------------

// File: rtl/mac_cfg_loader.sv
`default_nettype none
// mac_cfg_loader: collects CHUNK_WIDTH-wide beats into a CFG_WIDTH config word
// and strobes cset for one cycle after each correctly framed frame.
module mac_cfg_loader #(
    parameter  int MAC_CONF_WIDTH = 4,
    parameter  int MAC_MIN_WIDTH  = 8,
    parameter  int MAC_MULT_WIDTH = 2*MAC_MIN_WIDTH,
    parameter  int MAC_ACC_WIDTH  = 2*MAC_MULT_WIDTH,
    parameter  int CHUNK_WIDTH    = 8,
    localparam int CFG_WIDTH      = 4*MAC_ACC_WIDTH + MAC_CONF_WIDTH,
    localparam int NUM_BEATS      = (CFG_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [CHUNK_WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [CFG_WIDTH-1:0]   cfg,
    output logic                   cset,
    output logic                   busy,
    output logic                   err
);

    localparam int SHADOW_W = NUM_BEATS * CHUNK_WIDTH;
    localparam int CNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [SHADOW_W-1:0]   shadow_q;
    logic [SHADOW_W-1:0]   shadow_d;
    logic [CFG_WIDTH-1:0]  cfg_q;
    logic                  cset_q;
    logic                  err_q;
    logic                  accept;

    assign in_ready = en && !rst && (state_q != COMMIT);
    assign accept   = in_valid && in_ready;
    assign cfg      = cfg_q;
    assign cset     = cset_q;
    assign err      = err_q;
    assign busy     = (state_q == LOAD);

    // Shadow with the current beat merged in; the final beat's bits above
    // CFG_WIDTH fall off when cfg is loaded from this.
    always_comb begin
        shadow_d = shadow_q;
        shadow_d[int'(cnt_q)*CHUNK_WIDTH +: CHUNK_WIDTH] = in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            cfg_q    <= '0;
            cset_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (in_last) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q    <= 1'b0;
                            shadow_q <= shadow_d;
                            cnt_q    <= CNT_W'(1);
                            state_q  <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        if (cnt_q == LAST_CNT) begin
                            if (in_last) begin
                                cfg_q   <= shadow_d[CFG_WIDTH-1:0];
                                cset_q  <= 1'b1;
                                state_q <= COMMIT;
                            end else begin
                                err_q   <= 1'b1;
                                state_q <= IDLE;
                            end
                            cnt_q <= '0;
                        end else if (in_last) begin
                            err_q   <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            shadow_q <= shadow_d;
                            cnt_q    <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                COMMIT: begin
                    cset_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    cset_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
